sipo_frame_rx: RTL

Serial-to-parallel frame receiver that sits directly downstream of the 8-bit PISO shifter. It accepts the MSB-first bit stream the PISO emits, one bit per strobed cycle, and reassembles `DATA_WIDTH`-bit words. Completed words are presented on a single-entry valid/ready output register. Frame alignment comes from a start marker that travels with the first bit.

---
 rtl/serial_pkg.sv | 8 +
 rtl/sipo_out_reg.sv | 35 +++
 rtl/sipo_frame_rx.sv | 81 ++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// serial_pkg: shared FSM state type, default word width and counter-width helper.
package serial_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} rx_state_t;
  localparam int DEFAULT_DATA_WIDTH = 8;
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/sipo_out_reg.sv
// sipo_out_reg: single-entry valid/ready holding register with overrun pulse on dropped words.
module sipo_out_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         perr_in,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         parity_err,
  output logic         overrun
);
  logic accept;
  assign accept = load && (!out_valid || out_ready);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= load && out_valid && !out_ready;
      if (accept) begin
        out_data   <= din;
        parity_err <= perr_in;
        out_valid  <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/sipo_frame_rx.sv
// sipo_frame_rx: MSB-first serial frame receiver; SIPO_PARITY_EN adds a trailing even-parity bit.
module sipo_frame_rx
  import serial_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  serial_in,
  input  logic                  bit_valid,
  input  logic                  frame_start,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  parity_err,
  output logic                  overrun
);
  localparam int CW = cnt_w(DATA_WIDTH);
  rx_state_t             state, state_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [DATA_WIDTH-1:0] shreg, shreg_n;
  logic                  done, perr;
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    shreg_n = shreg;
    done    = 1'b0;
    perr    = 1'b0;
    if (bit_valid) begin
      if (frame_start) begin
        shreg_n = {shreg[DATA_WIDTH-2:0], serial_in};
        cnt_n   = CW'(1);
        state_n = SHIFT;
      end else if (state == SHIFT) begin
        shreg_n = {shreg[DATA_WIDTH-2:0], serial_in};
        cnt_n   = cnt + CW'(1);
        if (cnt_n == CW'(DATA_WIDTH)) begin
`ifdef SIPO_PARITY_EN
          state_n = PARITY;
`else
          done    = 1'b1;
          state_n = IDLE;
          cnt_n   = '0;
`endif
        end
      end
`ifdef SIPO_PARITY_EN
      else if (state == PARITY) begin
        done    = 1'b1;
        perr    = ^{shreg, serial_in};
        state_n = IDLE;
        cnt_n   = '0;
      end
`endif
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
      shreg <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      shreg <= shreg_n;
    end
  end
  // shreg_n equals the completed word in both builds (PARITY does not shift)
  sipo_out_reg #(.W(DATA_WIDTH)) u_out (
    .clk        (clk),
    .rstn       (rstn),
    .load       (done),
    .din        (shreg_n),
    .perr_in    (perr),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .parity_err (parity_err),
    .overrun    (overrun)
  );
endmodule
